instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder half of the control decoder: turns symbolic instruction requests (op_sel + fields) into 32-bit MIPS words.
//  Writes them sequentially into instruction memory through a one-port write interface.
//  Used to preload programs and by benches that need a program image without an assembler.
//  Encodings match the decoder exactly: addi 08, lw 23, sw 2B, beq 04, bne 05, j 02, jal 03, R-type 00, COP1 11.
// PARAMETERS
//  ADDR_W     8    instruction-memory word-address width
//  MAX_WORDS  256  words accepted per program, 1..2^ADDR_W
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       pulse: begin new program at word 0
//  finish      in   1       pulse: end program
//  req_valid   in   1       request valid
//  req_ready   out  1       request accepted when valid&ready
//  op_sel      in   5       instruction select, see BEHAVIOUR
//  rs,rt,rd    in   5 each  register fields (FP: fs=rs, ft=rt, fd=rd)
//  shamt       in   5       shift amount (SLL/SRL)
//  imm         in   16      immediate / branch offset (words, signed, used verbatim)
//  target      in   26      jump target field
//  imem_wen    out  1       memory write strobe
//  imem_addr   out  ADDR_W  word address
//  imem_wdata  out  32      encoded instruction
//  count       out  ADDR_W+1  legal words accepted this program
//  full        out  1       count==MAX_WORDS
//  done        out  1       program closed
//  err_illegal out  1       sticky: an illegal op_sel was consumed
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (imem_wen, imem_addr, imem_wdata, count, full, done, err_illegal, req_ready).
//  FSM states and transitions:
//   - IDLE -start-> RUN.
//   - RUN -finish-> DONE.
//   - DONE -start-> RUN.
//   - start in any state: count=0, err_illegal=0, done=0.
//  req_ready = (state==RUN) && (count<MAX_WORDS) && !finish; combinational.
//  Accept at edge N: on the next cycle (N+1) imem_wen=1, imem_addr=count, and count increments (registered, latency 1).
//  imem_wen is a single-cycle pulse per word; imem_wdata/imem_addr hold their last values otherwise.
//  op_sel encoding:
//   - R-type funct: 0 ADD 20, 1 SUB 22, 2 AND 24, 3 OR 25, 4 SLT 2A, 5 SLL 00, 6 SRL 02, 7 JR 08.
//     SLL/SRL: rs=0. JR: rt=rd=shamt=0.
//   - I-type {op,rs,rt,imm}: 8 ADDI, 9 LW, 10 SW, 11 BEQ, 12 BNE.
//   - J-type {op,target}: 13 J, 14 JAL.
//   - 15..31: FP group or illegal, see CONFIGURATION.
//  Illegal op_sel: still consumed (handshake completes), no write, count unchanged, err_illegal set.
//  full: full=1 once count==MAX_WORDS; req_ready drops; extra requests stall and are never written.
//  finish with a same-cycle handshake is impossible (ready masked).
//  A write pending from the prior edge completes before done=1 is seen.
//  Reset mid-program aborts any pending write; the memory image is left as-is.
// CONFIGURATION
//  Macro FP_ENCODE_EN.
//  Defined:
//   - 16 LWC1 op 31.
//   - 17 SWC1 op 39.
//   - 18 ADD.S {11,fmt=10,ft,fs,fd,00}.
//   - 19 ADD.D {11,fmt=11,ft,fs,fd,00}.
//   - 20 BC1T {11,08,01,imm}.
//   - 15 and 21..31 illegal.
//  Undefined: op_sel 15..31 all illegal; no COP1 logic synthesised.
// TESTING
//  T1 start; ADDI rs=0 rt=8 imm=0005 -> one cycle later imem_wen=1, addr 0, wdata 20080005, count=1.
//  T2 ADD rd=10 rs=8 rt=9, then LW rt=9 rs=29 imm=0004 back-to-back -> addr0 01095020, addr1 8FA90004.
//  T3 J target=0000010 then JAL same target -> 08000010, 0C000010; JR rs=31 -> 03E00008.
//  T4 MAX_WORDS=4, valid held for 5 reqs -> 4 writes (addr 0..3), full=1, req_ready=0, 5th never written.
//  T5 op_sel=21 -> no imem_wen, err_illegal=1, count unchanged; next start clears err_illegal.
//  T6 FP_ENCODE_EN defined: LWC1 rt=2 rs=29 imm=8 -> C7A20008; undefined: op_sel 16 -> err_illegal=1.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests into 32-bit MIPS words and streams them into instruction memory.
// Optional COP1 encodings (LWC1, SWC1, ADD.S, ADD.D, BC1T) are built only when FP_ENCODE_EN is defined.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, RUN, CLOSED} state_t;
  state_t state;

  // Bit 32 flags a legal op_sel; bits 31:0 carry the encoded word.
  function automatic logic [32:0] encode(input logic [4:0] op, input logic [4:0] f_rs,
                                         input logic [4:0] f_rt, input logic [4:0] f_rd,
                                         input logic [4:0] f_sh, input logic [15:0] f_imm,
                                         input logic [25:0] f_tgt);
    case (op)
      5'd0:  return {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h20};
      5'd1:  return {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h22};
      5'd2:  return {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h24};
      5'd3:  return {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h25};
      5'd4:  return {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h2A};
      5'd5:  return {1'b1, 6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h00};
      5'd6:  return {1'b1, 6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h02};
      5'd7:  return {1'b1, 6'h00, f_rs, 5'd0, 5'd0, 5'd0, 6'h08};
      5'd8:  return {1'b1, 6'h08, f_rs, f_rt, f_imm};
      5'd9:  return {1'b1, 6'h23, f_rs, f_rt, f_imm};
      5'd10: return {1'b1, 6'h2B, f_rs, f_rt, f_imm};
      5'd11: return {1'b1, 6'h04, f_rs, f_rt, f_imm};
      5'd12: return {1'b1, 6'h05, f_rs, f_rt, f_imm};
      5'd13: return {1'b1, 6'h02, f_tgt};
      5'd14: return {1'b1, 6'h03, f_tgt};
`ifdef FP_ENCODE_EN
      5'd16: return {1'b1, 6'h31, f_rs, f_rt, f_imm};
      5'd17: return {1'b1, 6'h39, f_rs, f_rt, f_imm};
      5'd18: return {1'b1, 6'h11, 5'h10, f_rt, f_rs, f_rd, 6'h00};
      5'd19: return {1'b1, 6'h11, 5'h11, f_rt, f_rs, f_rd, 6'h00};
      5'd20: return {1'b1, 6'h11, 5'h08, 5'h01, f_imm};
`endif
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  logic [32:0]     enc;
  logic            accept;
  logic [ADDR_W:0] base;

  assign enc       = encode(op_sel, rs, rt, rd, shamt, imm, target);
  assign req_ready = (state == RUN) && (count < MAX_CNT) && !finish;
  assign accept    = req_valid && req_ready;
  assign full      = (count == MAX_CNT);
  // A start coinciding with a handshake rewinds the program, so that word lands at 0.
  assign base      = start ? '0 : count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      imem_wen    <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      count       <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      imem_wen <= 1'b0;
      if (start) begin
        state       <= RUN;
        count       <= '0;
        done        <= 1'b0;
        err_illegal <= 1'b0;
      end else if (state == RUN && finish) begin
        state <= CLOSED;
        done  <= 1'b1;
      end
      if (accept) begin
        if (enc[32]) begin
          imem_wen   <= 1'b1;
          imem_addr  <= base[ADDR_W-1:0];
          imem_wdata <= enc[31:0];
          count      <= base + 1'b1;
        end else begin
          err_illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes queued at handshake, checked when imem_wen fires.
module tb_instr_encoder_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, finish, req_valid, req_ready;
  logic [4:0]        op_sel, rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full, done, err_illegal;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .imem_wen(imem_wen), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .done(done), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  model_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {63'd0, imem_wen}, 64'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", {56'd0, imem_addr}, {56'd0, w.addr});
        check("wr_data", {32'd0, imem_wdata}, {32'd0, w.data});
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_cnt = 0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  // legal=0 means the request is consumed but must not be written.
  task automatic send(input logic [4:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [15:0] a_imm,
                      input logic [25:0] a_tgt, input bit legal, input logic [31:0] exp_word);
    int budget;
    wr_t w;
    op_sel = op; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh; imm = a_imm; target = a_tgt;
    req_valid = 1'b1;
    budget = 20;
    #1;
    while (req_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (req_ready !== 1'b1) begin
      check("handshake_timeout", {63'd0, req_ready}, 64'd1);
    end else begin
      if (legal) begin
        w.addr = ADDR_W'(model_cnt);
        w.data = exp_word;
        exp_q.push_back(w);
        model_cnt++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
    repeat (3) @(negedge clk);
    check("rst_wen",   {63'd0, imem_wen}, 64'd0);
    check("rst_addr",  {56'd0, imem_addr}, 64'd0);
    check("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    check("rst_count", {55'd0, count}, 64'd0);
    check("rst_flags", {60'd0, full, done, err_illegal, req_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {63'd0, req_ready}, 64'd0);

    // T1: single ADDI
    pulse_start();
    check("run_ready", {63'd0, req_ready}, 64'd1);
    send(5'd8, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b1, 32'h20080005);
    check("t1_count", {55'd0, count}, 64'd1);

    // T2: back-to-back R-type and load, plus store
    pulse_start();
    check("t2_count0", {55'd0, count}, 64'd0);
    send(5'd0, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0, 26'd0, 1'b1, 32'h01095020);
    send(5'd9, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b1, 32'h8FA90004);
    send(5'd10, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b1, 32'hAFA90004);
    check("t2_count", {55'd0, count}, 64'd3);

    // T3: jumps, JR/SLL field forcing, finish/done
    pulse_start();
    send(5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1, 32'h08000010);
    send(5'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1, 32'h0C000010);
    send(5'd7, 5'd31, 5'd5, 5'd5, 5'd5, 16'h0, 26'd0, 1'b1, 32'h03E00008);
    send(5'd5, 5'd7, 5'd9, 5'd10, 5'd4, 16'h0, 26'd0, 1'b1, 32'h00095100);
    pulse_finish();
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_done_ready", {63'd0, req_ready}, 64'd0);
    pulse_start();
    check("t3_restart_done", {63'd0, done}, 64'd0);

    // T4: fill to MAX_WORDS, fifth request stalls
    send(5'd11, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFE, 26'd0, 1'b1, 32'h1109FFFE);
    send(5'd12, 5'd8, 5'd9, 5'd0, 5'd0, 16'h0003, 26'd0, 1'b1, 32'h15090003);
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 1'b1, 32'h00221822);
    send(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 1'b1, 32'h0022182A);
    check("t4_full", {63'd0, full}, 64'd1);
    check("t4_count", {55'd0, count}, 64'd4);
    op_sel = 5'd8; rs = 5'd0; rt = 5'd1; imm = 16'h0001;
    req_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_stall_ready", {63'd0, req_ready}, 64'd0);
    check("t4_stall_count", {55'd0, count}, 64'd4);
    req_valid = 1'b0;

    // T5: illegal op consumed without write; start clears the sticky flag
    pulse_start();
    send(5'd21, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'd0, 1'b0, 32'h0);
    check("t5_err", {63'd0, err_illegal}, 64'd1);
    check("t5_count", {55'd0, count}, 64'd0);
    send(5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'd0, 1'b1, 32'h00853025);
    check("t5_err_sticky", {63'd0, err_illegal}, 64'd1);
    pulse_start();
    check("t5_err_clr", {63'd0, err_illegal}, 64'd0);

    // T6: FP group depends on build option
`ifdef FP_ENCODE_EN
    send(5'd16, 5'd29, 5'd2, 5'd0, 5'd0, 16'h0008, 26'd0, 1'b1, 32'hC7A20008);
    send(5'd18, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 1'b1, 32'h460208C0);
    check("t6_err", {63'd0, err_illegal}, 64'd0);
`else
    send(5'd16, 5'd29, 5'd2, 5'd0, 5'd0, 16'h0008, 26'd0, 1'b0, 32'h0);
    check("t6_err", {63'd0, err_illegal}, 64'd1);
`endif
    send(5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0, 1'b0, 32'h0);
    check("t6_op15_err", {63'd0, err_illegal}, 64'd1);
    check("t6_count", {55'd0, count}, 64'(model_cnt));

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
